// File: rtl/sram_arbiter_pkg.sv
// arb_pkg: shared FSM state, owner encoding and write-enable constant for sram_arbiter
package arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
   typedef enum logic {OWN_INST, OWN_DATA} arb_owner_t;
   localparam logic [3:0] ARB_WEN_NONE = 4'b0;
endpackage

// File: rtl/sram_arbiter_pick.sv
// arb_pick: combinational winner select between fetch and memory-stage requests
//   in : req_inst, req_data, mask_owner_valid/mask_owner (requester excluded this cycle), last_winner
//   out: grant_valid, grant_owner
//   SRAM_ARB_RR_EN selects round-robin on contention; otherwise data has fixed priority.
module arb_pick
   import arb_pkg::*;
(
   input  logic       req_inst,
   input  logic       req_data,
   input  logic       mask_owner_valid,
   input  arb_owner_t mask_owner,
   input  arb_owner_t last_winner,
   output logic       grant_valid,
   output arb_owner_t grant_owner
);
   logic inst_ok, data_ok;
`ifndef SRAM_ARB_RR_EN
   logic unused_last_winner;
   assign unused_last_winner = last_winner;
`endif
   always_comb begin
      inst_ok     = req_inst && !(mask_owner_valid && mask_owner == OWN_INST);
      data_ok     = req_data && !(mask_owner_valid && mask_owner == OWN_DATA);
      grant_valid = inst_ok || data_ok;
`ifdef SRAM_ARB_RR_EN
      // on contention, favour whichever requester did not win last
      grant_owner = (inst_ok && data_ok) ? ((last_winner == OWN_INST) ? OWN_DATA : OWN_INST)
                                         : (data_ok ? OWN_DATA : OWN_INST);
`else
      grant_owner = data_ok ? OWN_DATA : OWN_INST;
`endif
   end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port data SRAM between instruction fetch and the memory stage
//   clk/rst (sync, active-low); inst_req/addr -> inst_ack/rdata; data_req/wen/addr/wdata -> data_ack/rdata
//   mem_en/wen/addr/wdata drive the SRAM (registered); mem_rdata returns a cycle after mem_en.
//   Define SRAM_ARB_RR_EN for round-robin arbitration with a last-winner flop.
module sram_arbiter
   import arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_ack,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_ack,
   output logic [31:0] data_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   arb_state_t  state_q, state_d;
   arb_owner_t  owner_q, owner_d, last_q, grant_owner;
   logic        grant_valid, latch, resp;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  wen_q, wen_d, mem_wen_q, mem_wen_d;
   logic        mem_en_q, mem_en_d;

   arb_pick u_pick (
      .req_inst         (inst_req),
      .req_data         (data_req),
      .mask_owner_valid (state_q == RESP),
      .mask_owner       (owner_q),
      .last_winner      (last_q),
      .grant_valid      (grant_valid),
      .grant_owner      (grant_owner)
   );

   always_comb begin
      // a new request can only be taken when the port is not being driven this cycle
      latch     = (state_q != ISSUE) && grant_valid;
      state_d   = (state_q == ISSUE) ? RESP : (latch ? ISSUE : IDLE);
      owner_d   = latch ? grant_owner : owner_q;
      addr_d    = latch ? ((grant_owner == OWN_DATA) ? data_addr : inst_addr) : addr_q;
      wen_d     = latch ? ((grant_owner == OWN_DATA) ? data_wen : ARB_WEN_NONE) : wen_q;
      wdata_d   = latch ? ((grant_owner == OWN_DATA) ? data_wdata : 32'h0) : wdata_q;
      mem_en_d  = (state_d == ISSUE);
      mem_wen_d = mem_en_d ? wen_d : ARB_WEN_NONE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_INST;
         addr_q    <= '0;
         wen_q     <= ARB_WEN_NONE;
         wdata_q   <= '0;
         mem_en_q  <= 1'b0;
         mem_wen_q <= ARB_WEN_NONE;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         mem_en_q  <= mem_en_d;
         mem_wen_q <= mem_wen_d;
      end
   end

`ifdef SRAM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!rst)
         last_q <= OWN_INST;
      else if (latch)
         last_q <= grant_owner;
   end
`else
   assign last_q = OWN_INST;
`endif

   // reset low drops the transaction, so no ack may leave during it
   assign resp       = rst && (state_q == RESP);
   assign inst_ack   = resp && (owner_q == OWN_INST);
   assign data_ack   = resp && (owner_q == OWN_DATA);
   assign inst_rdata = inst_ack ? mem_rdata : 32'h0;
   assign data_rdata = data_ack ? mem_rdata : 32'h0;
   assign mem_en     = mem_en_q;
   assign mem_wen    = mem_wen_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random checks of sram_arbiter against a cycle-schedule model
module tb_sram_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req = 1'b0, data_req = 1'b0;
   logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
   logic [3:0]  data_wen = '0;
   logic        inst_ack, data_ack, mem_en;
   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wen;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_ack(data_ack), .data_rdata(data_rdata),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;

   // model: the latched transaction and the cycle on which it drives the SRAM
   typedef struct {
      bit          valid;
      bit          own;
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
      int          iss;
   } txn_t;
   txn_t t;
   bit grants[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit exp_ack(input bit own);
      return t.valid && cyc == t.iss + 1 && t.own == own;
   endfunction

   task automatic model_update();
      bit ci, cd, busy, excl_v;
      if (!rst) begin
         t = '{valid: 1'b0, own: 1'b0, addr: '0, wen: '0, wdata: '0, iss: -10};
         return;
      end
      busy   = t.valid && cyc == t.iss;
      excl_v = t.valid && cyc == t.iss + 1;
      ci     = inst_req && !(excl_v && t.own == 1'b0);
      cd     = data_req && !(excl_v && t.own == 1'b1);
      if (!busy && (ci || cd)) begin
         t.valid = 1'b1;
         t.own   = cd;
         t.addr  = cd ? data_addr : inst_addr;
         t.wen   = cd ? data_wen : 4'b0;
         t.wdata = cd ? data_wdata : 32'h0;
         t.iss   = cyc + 1;
         grants.push_back(cd);
      end
   endtask

   task automatic tick(input bit force_rd = 1'b0, input logic [31:0] rd = '0);
      bit en;
      model_update();
      @(posedge clk);
      #1;
      cyc++;
      mem_rdata = force_rd ? rd : $urandom;
      #1;
      en = t.valid && cyc == t.iss;
      chk("mem_en", mem_en, en);
      chk("mem_wen", mem_wen, en ? t.wen : 4'b0);
      chk("mem_addr", mem_addr, t.addr);
      if (!(t.valid && t.own == 1'b0))
         chk("mem_wdata", mem_wdata, t.wdata);
      chk("inst_ack", inst_ack, exp_ack(1'b0));
      chk("data_ack", data_ack, exp_ack(1'b1));
      chk("inst_rdata", inst_rdata, exp_ack(1'b0) ? mem_rdata : 32'h0);
      chk("data_rdata", data_rdata, exp_ack(1'b1) ? mem_rdata : 32'h0);
   endtask

   initial begin
      tick();
      rst = 1'b1;
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_inst_ack", inst_ack, 1'b0);
      tick();

      // instruction read alone
      inst_req = 1'b1; inst_addr = 32'h100;
      tick();
      chk("d1_en", mem_en, 1'b1);
      chk("d1_wen", mem_wen, 4'b0);
      chk("d1_addr", mem_addr, 32'h100);
      tick(1'b1, 32'hDEADBEEF);
      chk("d1_ack", inst_ack, 1'b1);
      chk("d1_rdata", inst_rdata, 32'hDEADBEEF);
      chk("d1_dack", data_ack, 1'b0);
      inst_req = 1'b0;
      tick();

      // data byte write
      data_req = 1'b1; data_wen = 4'b0100; data_addr = 32'h202; data_wdata = 32'h5A5A5A5A;
      tick();
      chk("d2_wen", mem_wen, 4'b0100);
      chk("d2_wdata", mem_wdata, 32'h5A5A5A5A);
      chk("d2_addr", mem_addr, 32'h202);
      tick();
      chk("d2_ack", data_ack, 1'b1);
      data_req = 1'b0; data_wen = 4'b0;
      tick();

      // simultaneous requests: data first, inst with no idle gap
      inst_req = 1'b1; inst_addr = 32'h0; data_req = 1'b1; data_addr = 32'h40;
      tick();
      chk("d3_den", mem_en, 1'b1);
      chk("d3_daddr", mem_addr, 32'h40);
      tick();
      chk("d3_dack", data_ack, 1'b1);
      data_req = 1'b0;
      tick();
      chk("d3_ien", mem_en, 1'b1);
      chk("d3_iaddr", mem_addr, 32'h0);
      tick();
      chk("d3_iack", inst_ack, 1'b1);
      inst_req = 1'b0;
      tick();

      // data request held for three back-to-back transactions
      data_req = 1'b1; data_addr = 32'h80; data_wen = 4'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("d4_en", mem_en, k == 1 || k == 4 || k == 7);
         chk("d4_ack", data_ack, k == 2 || k == 5 || k == 8);
         if (k == 8) data_req = 1'b0;
      end

      // both held: RESP exclusion forces alternation
      grants.delete();
      inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h10; data_addr = 32'h20;
      for (int k = 0; k < 20 && grants.size() < 4; k++) tick();
      chk("d5_cnt", grants.size() >= 4, 1'b1);
      chk("d5_g0", grants[0], 1'b1);
      chk("d5_g1", grants[1], 1'b0);
      chk("d5_g2", grants[2], 1'b1);
      chk("d5_g3", grants[3], 1'b0);
      inst_req = 1'b0; data_req = 1'b0;
      repeat (4) tick();

      // reset during ISSUE drops the access
      inst_req = 1'b1; inst_addr = 32'h300;
      tick();
      chk("d6_en", mem_en, 1'b1);
      rst = 1'b0;
      tick();
      chk("d6_rst_en", mem_en, 1'b0);
      chk("d6_rst_ack", inst_ack, 1'b0);
      chk("d6_rst_addr", mem_addr, 32'h0);
      rst = 1'b1;
      tick();
      chk("d6_re_en", mem_en, 1'b1);
      chk("d6_re_addr", mem_addr, 32'h300);
      tick();
      chk("d6_re_ack", inst_ack, 1'b1);
      inst_req = 1'b0;
      tick();

      // random requesters, each holding req until its ack
      for (int k = 0; k < 500; k++) begin
         tick();
         if (!inst_req || exp_ack(1'b0)) begin
            inst_req  = ($urandom_range(0, 2) != 0);
            inst_addr = $urandom;
         end
         if (!data_req || exp_ack(1'b1)) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_wen   = $urandom_range(0, 1) ? 4'b0 : 4'($urandom);
         end
      end
      inst_req = 1'b0; data_req = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port data SRAM between the instruction-fetch stage and the memory stage. Each requester presents a held request; the arbiter latches one, drives the SRAM port for one cycle, and returns an acknowledge with read data when the SRAM responds a cycle later. It sits between the fetch unit / `memory` stage SRAM-side signals and the physical SRAM.

## Interface
- No parameters; address and data widths are fixed at 32, byte enables at 4.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `inst_req` in 1: fetch request, held until `inst_ack`; always a read.
- `inst_addr` in 32: fetch address, stable while `inst_req` is high.
- `inst_ack` out 1: one-cycle pulse; fetch request complete.
- `inst_rdata` out 32: fetch data, valid only while `inst_ack` is high.
- `data_req` in 1: memory-stage request (the stage's `mem_en`), held until `data_ack`.
- `data_wen` in 4: byte write enables; 0 means read.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data, pre-replicated by the memory stage.
- `data_ack` out 1: one-cycle pulse; data request complete.
- `data_rdata` out 32: read data, valid only while `data_ack` is high.
- `mem_en` out 1: SRAM enable.
- `mem_wen` out 4: SRAM byte write enables.
- `mem_addr` out 32: SRAM address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid the cycle after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:**
  - If any request is pending, pick a winner and latch its addr/wen/wdata plus a 1-bit owner id.
  - Then go to ISSUE.
- **ISSUE:**
  - `mem_en`=1.
  - `mem_addr`/`mem_wen`/`mem_wdata` come from the latch. `mem_wen`=0 for an instruction owner.
  - Always go to RESP.
- **RESP:**
  - Pulse the owner's ack. Route `mem_rdata` to the owner's rdata. Writes are acked the same way.
  - Arbitrate only among non-owner requests; the owner's `req` is ignored this cycle.
  - If a non-owner request wins, latch it and go to ISSUE; otherwise go to IDLE.
- **Arbitration:** data has fixed priority over instruction (see Configuration).
- A requester may keep `req` high after its ack to start a new transaction. That new request is eligible from the cycle after the ack.
- In IDLE and RESP, `mem_en`=0, `mem_wen`=0, and `mem_addr`/`mem_wdata` hold the latch contents.
- Requester inputs are sampled only at the latch; changes after that have no effect on the transaction in flight.

## Timing
- Reset values:
  - state IDLE, latch 0, owner=inst.
  - `mem_en`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
  - `inst_ack`=0, `data_ack`=0.
  - rdata outputs 0 when their ack is low.
- Latency: `req` seen in IDLE at cycle T gives `mem_en` at T+1 and ack at T+2.
- Alternating requesters: one transaction every 2 cycles. Same requester back-to-back: one every 3 cycles.
- Both requests arrive in the same cycle: data wins. Inst then issues at T+3 and is acked at T+4.
- `rst` low mid-transaction: the in-flight access is dropped, no ack is issued, and next cycle is IDLE with reset outputs. The requester re-presents after reset.
- Ack and rdata outputs are combinational from state and `mem_rdata`. SRAM port outputs are registered.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Round-robin when both requesters contend. A last-winner flop (reset to inst) gives priority to the requester that did not win last.
  - RESP exclusion still applies.
- Not defined:
  - Fixed data-over-inst priority and no last-winner flop.
  - Instruction starvation is acceptable because the memory stage stalls the pipeline.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, RESP}.
  - `arb_owner_t` enum {OWN_INST, OWN_DATA}.
  - Constant `ARB_WEN_NONE`=4'b0.
- One sub-module `arb_pick`: combinational picker with inputs `req_inst`, `req_data`, `mask_owner_valid`, `mask_owner`, `last_winner`, and outputs `grant_valid`, `grant_owner`.
  - The macro selects its policy.
- Top level holds the FSM, request latch, owner flop and output muxing.

## Test plan
- Inst read alone, addr 0x100, SRAM returns 0xDEADBEEF:
  - `mem_en` at T+1 with `mem_wen`=0 and `mem_addr`=0x100.
  - `inst_ack`=1 with `inst_rdata`=0xDEADBEEF at T+2; `data_ack` stays 0.
- Data byte write, wen 4'b0100, addr 0x202, wdata 0x5A5A5A5A:
  - `mem_wen`=4'b0100 and `mem_wdata`=0x5A5A5A5A at T+1.
  - `data_ack` at T+2.
- Simultaneous inst 0x0 and data 0x40 reads:
  - Data issues at T+1 and is acked at T+2.
  - Inst issues at T+3 and is acked at T+4; no idle cycle between the two transactions.
- Data `req` held high continuously for 3 transactions, inst idle:
  - Acks at T+2, T+5 and T+8.
  - `mem_en` high only at T+1, T+4 and T+7.
- With `SRAM_ARB_RR_EN`, both requesters held high:
  - Grant order inst, data, inst, data.
  - Without the macro: grant order data, inst, data, inst (RESP exclusion forces alternation).
- `rst` low in the ISSUE cycle:
  - No ack is issued.
  - Next cycle all outputs are at reset values and state is IDLE.
  - After release, the held request completes 2 cycles after the arbiter sees it in IDLE.
